// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/branch controls and instruction memory return in,
// PC and IF/ID pipeline register out.
interface fetch_if;
  // Handshake: there is no valid/ready pair. Every input is sampled on each posedge
  // and takes effect on that edge. BranchTarget matters only while BranchTaken=1.
  // InstReg must return the word addressed by Pc within the same cycle.
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] InstReg;
  logic [31:0] Pc;
  logic [31:0] IfIdInst;
  logic [31:0] IfIdPcPlus4;
  logic        IfIdValid;
  logic [31:0] FetchCount;
  logic        DbgState;   // 0 = BOOT, 1 = RUN

  modport master (
    output Stall, BranchTaken, BranchTarget, InstReg,
    input  Pc, IfIdInst, IfIdPcPlus4, IfIdValid, FetchCount, DbgState
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, InstReg,
    output Pc, IfIdInst, IfIdPcPlus4, IfIdValid, FetchCount, DbgState
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the fetched word into IF/ID,
// and handles stalls, branch redirects with flush, and PC wrap.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input logic    Clk,
  input logic    Rst,
  fetch_if.slave bus
);

  localparam int          ADDR_BITS = $clog2(IMEM_WORDS * 4);
  localparam logic [31:0] PC_MASK   = 32'((64'd1 << ADDR_BITS) - 64'd1) & 32'hFFFF_FFFC;

  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_next;

  // Word-align and keep the address inside instruction memory.
  assign pc_next = (pc_q + 32'd4) & PC_MASK;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: begin
        // One bubble edge lets instruction memory settle on RESET_PC.
        inst_d  = NOP_INST;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.BranchTaken) begin
          pc_d    = bus.BranchTarget & PC_MASK;
          inst_d  = NOP_INST;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
        end else if (!bus.Stall) begin
          pc_d    = pc_next;
          inst_d  = bus.InstReg;
          pcp4_d  = pc_next;
          valid_d = 1'b1;
          if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign bus.Pc          = pc_q;
  assign bus.IfIdInst    = inst_q;
  assign bus.IfIdPcPlus4 = pcp4_q;
  assign bus.IfIdValid   = valid_q;
  assign bus.FetchCount  = cnt_q;
  assign bus.DbgState    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction memory model, per-cycle reference model
// compare, and directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024), .NOP_INST(NOP)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  logic [31:0] imem [0:1023];
  initial for (int i = 0; i < 1024; i++) imem[i] = 32'h100 + i;
  assign bus.InstReg = imem[bus.Pc[11:2]];

  // Reference model: what the fetch stage must hold after each edge.
  logic [31:0] m_pc, m_inst, m_pp4, m_cnt;
  logic        m_valid, m_booting;

  function automatic logic [31:0] wrap(input logic [31:0] x);
    return {20'd0, x[11:2], 2'b00};
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_pc <= 32'h0; m_inst <= NOP; m_pp4 <= 32'h0; m_valid <= 1'b0;
      m_cnt <= 32'h0; m_booting <= 1'b1;
    end else if (m_booting) begin
      m_inst <= NOP; m_pp4 <= 32'h0; m_valid <= 1'b0; m_booting <= 1'b0;
    end else if (bus.BranchTaken) begin
      m_pc <= wrap(bus.BranchTarget); m_inst <= NOP; m_pp4 <= 32'h0; m_valid <= 1'b0;
    end else if (!bus.Stall) begin
      m_inst  <= imem[m_pc / 4];
      m_pc    <= wrap(m_pc + 4);
      m_pp4   <= wrap(m_pc + 4);
      m_valid <= 1'b1;
      m_cnt   <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_pc",    bus.Pc,          m_pc);
      chk("model_inst",  bus.IfIdInst,    m_inst);
      chk("model_pcp4",  bus.IfIdPcPlus4, m_pp4);
      chk("model_valid", {31'd0, bus.IfIdValid}, {31'd0, m_valid});
      chk("model_count", bus.FetchCount,  m_cnt);
      chk("model_state", {31'd0, bus.DbgState}, {31'd0, !m_booting});
    end
  end

  task automatic drive(input logic br, input logic st, input logic [31:0] tgt);
    bus.BranchTaken  = br;
    bus.Stall        = st;
    bus.BranchTarget = tgt;
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    bus.Pc,          32'h0);
    chk({tag, "_inst"},  bus.IfIdInst,    NOP);
    chk({tag, "_pcp4"},  bus.IfIdPcPlus4, 32'h0);
    chk({tag, "_valid"}, {31'd0, bus.IfIdValid}, 32'd0);
    chk({tag, "_count"}, bus.FetchCount,  32'h0);
  endtask

  task automatic boot_seq(input string tag);
    // Stall and branch during BOOT must be ignored.
    drive(1'b1, 1'b1, 32'h0000_0800);
    tick();
    chk({tag, "_boot_pc"},    bus.Pc, 32'h0);
    chk({tag, "_boot_valid"}, {31'd0, bus.IfIdValid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk({tag, "_first_inst"}, bus.IfIdInst,    32'h100);
    chk({tag, "_first_pcp4"}, bus.IfIdPcPlus4, 32'h4);
    chk({tag, "_first_valid"},{31'd0, bus.IfIdValid}, 32'd1);
    chk({tag, "_first_pc"},   bus.Pc,          32'h4);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge Clk);
    #1;
    cmp_en = 1'b1;
    chk_reset_vals("reset");
    Rst = 1'b0;

    // Reset/boot, then sequential fetch to five valid words.
    boot_seq("boot1");
    repeat (4) tick();
    chk("seq_inst",  bus.IfIdInst,   32'h104);
    chk("seq_pc",    bus.Pc,         32'h14);
    chk("seq_count", bus.FetchCount, 32'd5);

    // Redirect to 0x8 then stall three cycles.
    drive(1'b1, 1'b0, 32'h8);
    tick();
    chk("br8_pc", bus.Pc, 32'h8);
    drive(1'b0, 1'b1, 32'h0);
    repeat (3) tick();
    chk("stall_pc",    bus.Pc,         32'h8);
    chk("stall_inst",  bus.IfIdInst,   NOP);
    chk("stall_count", bus.FetchCount, 32'd5);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("unstall_inst",  bus.IfIdInst,   32'h102);
    chk("unstall_count", bus.FetchCount, 32'd6);

    // Branch wins over simultaneous stall; unaligned target.
    drive(1'b1, 1'b1, 32'h43);
    tick();
    chk("brst_pc",    bus.Pc,       32'h40);
    chk("brst_inst",  bus.IfIdInst, NOP);
    chk("brst_valid", {31'd0, bus.IfIdValid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("after_br_inst", bus.IfIdInst,    32'h110);
    chk("after_br_pcp4", bus.IfIdPcPlus4, 32'h44);

    // Wrap at the top of memory; high target bits must be cleared.
    drive(1'b1, 1'b0, 32'h1234_5FFC);
    tick();
    chk("wrap_pc0", bus.Pc, 32'hFFC);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_inst", bus.IfIdInst,    32'h4FF);
    chk("wrap_pcp4", bus.IfIdPcPlus4, 32'h0);
    chk("wrap_pc1",  bus.Pc,          32'h0);
    tick();
    chk("wrap_inst2", bus.IfIdInst, 32'h100);

    // Run to Pc=0x20, then async reset between edges.
    repeat (7) tick();
    chk("pre_rst_pc", bus.Pc, 32'h20);
    Rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    chk_reset_vals("rst_held");
    Rst = 1'b0;
    boot_seq("boot2");

    // Random stall/branch mix checked against the model every cycle.
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 32'hFFFF_FFFF));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
